plic: RTL and testbench
=======================

PLIC -- requirements
Module: plic

Interface
REQ-001 Parameter: NSRC, default 16, number of external interrupt sources; IDs 0..NSRC-1, core adds 4 to form mcause.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 irq_src_i  input  NSRC  raw interrupt lines from peripherals, synchronous to clk.
REQ-005 cfg_we_i  input  1  config register write strobe.
REQ-006 cfg_addr_i  input  3  config register select.
REQ-007 cfg_wdata_i  input  32  config write data.
REQ-008 cfg_rdata_o  output  32  config read data, combinational from cfg_addr_i.
REQ-009 ex_trap_valid_o  output  1  external interrupt offered to core.
REQ-010 ex_trap_id_o  output  5  ID of offered source; bit 4 always 0.
REQ-011 ex_trap_ready_i  input  1  core claim strobe; claims the ID on ex_trap_id_o that cycle.
REQ-012 ex_trap_cplet_i  input  1  one-cycle completion pulse from core (on MRET).

Function
REQ-013 Config map: 0 ENABLE[NSRC-1:0] RW; 1 PRIO, 2 bits per source, source k at [2k+1:2k], RW; 2 THRESH[1:0] RW; 3 PENDING RO; 4 {state[1:0] at [9:8], claimed ID at [4:0]} RO; other addresses read 0, writes ignored.
REQ-014 Writes to RO/unmapped addresses have no effect; unused RW bits read 0.
REQ-015 Gateway: pending[k] sets on a rising edge of irq_src_i[k] (previous-cycle sample 0, current 1); level high alone does not re-set.
REQ-016 pending[k] clears only on a claim of source k; if a rising edge of k coincides with its claim, pending[k] stays 1.
REQ-017 Eligible[k] = pending[k] & ENABLE[k] & (PRIO[k] > THRESH); PRIO 0 never eligible.
REQ-018 Arbitration: highest PRIO wins; ties go to lowest ID.
REQ-019 FSM states IDLE, OFFER, BUSY; state register only changes on clk.
REQ-020 IDLE: if any eligible -> OFFER, registering valid=1 and winner ID; else stay.
REQ-021 OFFER: ex_trap_valid_o=1, ex_trap_id_o re-registered each cycle from current arbitration (may change before claim).
REQ-022 OFFER with no eligible source -> IDLE, valid drops next cycle (withdrawal permitted).
REQ-023 OFFER with ex_trap_ready_i=1 -> BUSY; claimed ID := ex_trap_id_o; pending[claimed] cleared; valid=0 next cycle.
REQ-024 ex_trap_ready_i outside OFFER is ignored.
REQ-025 BUSY: valid=0; pending bits continue to accumulate; only ex_trap_cplet_i=1 -> IDLE, claimed ID cleared to 0.
REQ-026 ex_trap_cplet_i outside BUSY is ignored; only one claim outstanding at any time (no nesting).
REQ-027 Latency: source edge at cycle N -> pending at N+1 -> valid at N+2 (IDLE, eligible, enabled).
REQ-028 Config write and claim in same cycle both take effect; arbitration uses the new config from the next cycle.
REQ-029 Completion in cycle N with eligible pending source: IDLE at N+1, valid at N+2.

Reset
REQ-030 rst=1 at any edge, including mid-OFFER/BUSY: state IDLE, ENABLE/PRIO/THRESH/pending/claimed ID = 0, edge-detect history = 0, valid_o=0, id_o=0.
REQ-031 An irq line already high when rst deasserts produces no pending until it falls and rises again.

Verification
REQ-032 ENABLE=0x0004, PRIO[2]=1, THRESH=0; pulse src2 at N -> valid=1, id=2 at N+2; ready at N+3 -> valid=0, PENDING=0, state BUSY.
REQ-033 Sources 3 (PRIO 2) and 5 (PRIO 3) and 1 (PRIO 3) edge same cycle -> id=1 offered; after claim+cplet id=5, then id=3.
REQ-034 THRESH=2, src6 PRIO 2 pending -> no valid; write THRESH=1 -> valid, id=6 two cycles after write.
REQ-035 In BUSY, src4 edge -> no valid; PENDING[4]=1; cplet pulse -> valid, id=4 two cycles later.
REQ-036 Offer id=7 active, clear ENABLE[7] -> valid=0 within 2 cycles, PENDING[7] still 1; stray ready/cplet in IDLE -> no state change.
REQ-037 rst asserted in BUSY with pending bits -> all config/status reads 0, valid=0 next cycle, held-high source gives no offer after release.

Source files
------------

// File: rtl/plic.sv
// plic -- small platform-level interrupt controller for a single core.
//
// Latches rising edges of NSRC interrupt lines into pending bits. It then
// offers the highest-priority eligible source to the core, with ties going
// to the lowest ID. At most one claim is outstanding until the core
// signals completion.
//
// Ports
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   irq_src_i        raw interrupt lines, synchronous to clk
//   cfg_we_i         config write strobe
//   cfg_addr_i       config register select
//   cfg_wdata_i      config write data
//   cfg_rdata_o      config read data, combinational from cfg_addr_i
//   ex_trap_valid_o  external interrupt offered to the core
//   ex_trap_id_o     ID of the offered source (bit 4 always 0)
//   ex_trap_ready_i  claim strobe, honoured only while offering
//   ex_trap_cplet_i  completion pulse, honoured only while a claim is held
//
// Register map
//   0 ENABLE  RW   1 PRIO (2 bits/source) RW   2 THRESH[1:0] RW
//   3 PENDING RO   4 {state[9:8], claimed ID[4:0]} RO
//   State codes: IDLE=0, OFFER=1, BUSY=2.
//
// IDs are 5 bits wide with bit 4 always 0, so NSRC must not exceed 16.
module plic #(
   parameter int NSRC = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq_src_i,
   input  logic            cfg_we_i,
   input  logic [2:0]      cfg_addr_i,
   input  logic [31:0]     cfg_wdata_i,
   output logic [31:0]     cfg_rdata_o,
   output logic            ex_trap_valid_o,
   output logic [4:0]      ex_trap_id_o,
   input  logic            ex_trap_ready_i,
   input  logic            ex_trap_cplet_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      BUSY  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [NSRC-1:0]   enable_q, enable_d;
   logic [2*NSRC-1:0] prio_q, prio_d;
   logic [1:0]        thresh_q, thresh_d;
   logic [NSRC-1:0]   pending_q, pending_d;
   logic [NSRC-1:0]   irq_prev_q, irq_prev_d;
   logic              armed_q, armed_d;
   logic [4:0]        claimed_q, claimed_d;
   logic              valid_q, valid_d;
   logic [4:0]        id_q, id_d;

   logic [NSRC-1:0]   rise;
   logic [NSRC-1:0]   eligible;
   logic [NSRC-1:0]   clr_mask;
   logic              claim;
   logic              any_elig;
   logic [4:0]        win_id;
   logic [1:0]        win_prio;

   // Gateway and arbitration
   always_comb begin
      // armed_q is low for the first cycle after reset, so a line that is
      // already high at release does not count as an edge.
      rise = irq_src_i & ~irq_prev_q & {NSRC{armed_q}};
      for (int k = 0; k < NSRC; k++) begin
         eligible[k] = pending_q[k] & enable_q[k] & (prio_q[2*k +: 2] > thresh_q);
      end
      any_elig = 1'b0;
      win_id   = '0;
      win_prio = '0;
      // A strict '>' keeps the first (lowest) ID on a tie.
      for (int k = 0; k < NSRC; k++) begin
         if (eligible[k] && (!any_elig || (prio_q[2*k +: 2] > win_prio))) begin
            any_elig = 1'b1;
            win_prio = prio_q[2*k +: 2];
            win_id   = k[4:0];
         end
      end
   end

   assign claim    = (state_q == OFFER) && ex_trap_ready_i;
   assign clr_mask = claim ? ({{(NSRC-1){1'b0}}, 1'b1} << id_q) : '0;

   // Config, pending and FSM next state
   always_comb begin
      enable_d   = enable_q;
      prio_d     = prio_q;
      thresh_d   = thresh_q;
      irq_prev_d = irq_src_i;
      armed_d    = 1'b1;
      // A new edge on the source being claimed wins over the clear.
      pending_d  = (pending_q & ~clr_mask) | rise;
      state_d    = state_q;
      valid_d    = valid_q;
      id_d       = id_q;
      claimed_d  = claimed_q;

      if (cfg_we_i) begin
         case (cfg_addr_i)
            3'd0:    enable_d = cfg_wdata_i[NSRC-1:0];
            3'd1:    prio_d   = cfg_wdata_i[2*NSRC-1:0];
            3'd2:    thresh_d = cfg_wdata_i[1:0];
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (any_elig) begin
               state_d = OFFER;
               valid_d = 1'b1;
               id_d    = win_id;
            end
         end
         OFFER: begin
            if (ex_trap_ready_i) begin
               state_d   = BUSY;
               valid_d   = 1'b0;
               id_d      = '0;
               claimed_d = id_q;
            end else if (any_elig) begin
               // The offer may change to a better source before the claim.
               id_d = win_id;
            end else begin
               state_d = IDLE;
               valid_d = 1'b0;
               id_d    = '0;
            end
         end
         BUSY: begin
            if (ex_trap_cplet_i) begin
               state_d   = IDLE;
               claimed_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            id_d    = '0;
         end
      endcase
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         enable_q   <= '0;
         prio_q     <= '0;
         thresh_q   <= '0;
         pending_q  <= '0;
         irq_prev_q <= '0;
         armed_q    <= 1'b0;
         claimed_q  <= '0;
         valid_q    <= 1'b0;
         id_q       <= '0;
      end else begin
         state_q    <= state_d;
         enable_q   <= enable_d;
         prio_q     <= prio_d;
         thresh_q   <= thresh_d;
         pending_q  <= pending_d;
         irq_prev_q <= irq_prev_d;
         armed_q    <= armed_d;
         claimed_q  <= claimed_d;
         valid_q    <= valid_d;
         id_q       <= id_d;
      end
   end

   assign ex_trap_valid_o = valid_q;
   assign ex_trap_id_o    = id_q;

   // Register read-back
   always_comb begin
      cfg_rdata_o = '0;
      case (cfg_addr_i)
         3'd0: cfg_rdata_o[NSRC-1:0]   = enable_q;
         3'd1: cfg_rdata_o[2*NSRC-1:0] = prio_q;
         3'd2: cfg_rdata_o[1:0]        = thresh_q;
         3'd3: cfg_rdata_o[NSRC-1:0]   = pending_q;
         3'd4: begin
            cfg_rdata_o[9:8] = state_q;
            cfg_rdata_o[4:0] = claimed_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_plic.sv
// tb_plic -- self-checking bench for plic. A cycle-level reference model
// tracks pending bits, configuration and the offer/claim handshake. The
// model's results are compared with the DUT every cycle. Directed scenarios
// add hand-computed literal expectations.
module tb_plic;

   localparam int NSRC = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [NSRC-1:0] irq_src_i;
   logic            cfg_we_i;
   logic [2:0]      cfg_addr_i;
   logic [31:0]     cfg_wdata_i;
   logic [31:0]     cfg_rdata_o;
   logic            ex_trap_valid_o;
   logic [4:0]      ex_trap_id_o;
   logic            ex_trap_ready_i;
   logic            ex_trap_cplet_i;

   int n_cmp  = 0;
   int n_fail = 0;

   plic #(.NSRC(NSRC)) dut (
      .clk             (clk),
      .rst             (rst),
      .irq_src_i       (irq_src_i),
      .cfg_we_i        (cfg_we_i),
      .cfg_addr_i      (cfg_addr_i),
      .cfg_wdata_i     (cfg_wdata_i),
      .cfg_rdata_o     (cfg_rdata_o),
      .ex_trap_valid_o (ex_trap_valid_o),
      .ex_trap_id_o    (ex_trap_id_o),
      .ex_trap_ready_i (ex_trap_ready_i),
      .ex_trap_cplet_i (ex_trap_cplet_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] m_en, m_pend, m_prev;
   int          m_prio[16];
   int          m_thr;
   bit          m_armed, m_offering, m_outstanding;
   int          m_id, m_claimed;
   bit          m_started = 0;

   // Highest priority level first; within a level the lowest ID.
   function automatic int winner();
      for (int p = 3; p >= 1; p--) begin
         if (p > m_thr) begin
            for (int i = 0; i < NSRC; i++) begin
               if (m_pend[i] && m_en[i] && m_prio[i] == p) return i;
            end
         end
      end
      return -1;
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      logic [31:0] r;
      r = 32'h0;
      case (a)
         3'd0: r = {16'h0, m_en};
         3'd1: for (int i = 0; i < NSRC; i++) r = r | (32'(m_prio[i]) << (2 * i));
         3'd2: r = 32'(m_thr);
         3'd3: r = {16'h0, m_pend};
         3'd4: r = (32'(m_outstanding ? 2 : (m_offering ? 1 : 0)) << 8) | 32'(m_claimed);
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      int          best;
      bit          clm;
      logic [15:0] rises;
      if (rst) begin
         m_en = '0; m_pend = '0; m_prev = '0; m_thr = 0; m_armed = 0;
         for (int i = 0; i < NSRC; i++) m_prio[i] = 0;
         m_offering = 0; m_outstanding = 0; m_id = 0; m_claimed = 0;
      end else begin
         best  = winner();
         clm   = m_offering && ex_trap_ready_i;
         rises = m_armed ? (irq_src_i & ~m_prev) : 16'h0;
         if (clm) m_pend[m_id] = 1'b0;
         m_pend  = m_pend | rises;
         m_prev  = irq_src_i;
         m_armed = 1;
         if (cfg_we_i) begin
            case (cfg_addr_i)
               3'd0: m_en = cfg_wdata_i[15:0];
               3'd1: for (int i = 0; i < NSRC; i++) m_prio[i] = int'(cfg_wdata_i[2*i +: 2]);
               3'd2: m_thr = int'(cfg_wdata_i[1:0]);
               default: ;
            endcase
         end
         if (m_outstanding) begin
            if (ex_trap_cplet_i) begin m_outstanding = 0; m_claimed = 0; end
         end else if (m_offering) begin
            if (clm) begin m_outstanding = 1; m_claimed = m_id; m_offering = 0; end
            else if (best >= 0) m_id = best;
            else m_offering = 0;
         end else if (best >= 0) begin
            m_offering = 1; m_id = best;
         end
      end
      m_started = 1;
      // Compare away from the edge, once DUT and model have both settled.
      #2;
      check("valid", {31'h0, ex_trap_valid_o}, {31'h0, m_offering});
      if (m_offering) check("id", {27'h0, ex_trap_id_o}, 32'(m_id));
      check("rdata", cfg_rdata_o, m_read(cfg_addr_i));
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
      cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
      tick();
      cfg_we_i = 1'b0; cfg_wdata_i = '0;
   endtask

   task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
      cfg_addr_i = a;
      #1;
      check(name, cfg_rdata_o, exp);
   endtask

   task automatic claim_and_complete();
      ex_trap_ready_i = 1'b1; tick(); ex_trap_ready_i = 1'b0;
      ex_trap_cplet_i = 1'b1; tick(); ex_trap_cplet_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1; irq_src_i = '0; cfg_we_i = 1'b0; cfg_addr_i = 3'd0;
      cfg_wdata_i = '0; ex_trap_ready_i = 1'b0; ex_trap_cplet_i = 1'b0;
      tick(3);
      check("rst_valid", {31'h0, ex_trap_valid_o}, 32'h0);
      check("rst_id", {27'h0, ex_trap_id_o}, 32'h0);
      rd_check("rst_status", 3'd4, 32'h0);
      rst = 1'b0;
      tick(2);

      // Single source: edge -> pending -> offer, then claim.
      cfg_write(3'd0, 32'h0004);
      cfg_write(3'd1, 32'h0000_0010);
      cfg_write(3'd2, 32'h0);
      irq_src_i = 16'h0004; tick();
      rd_check("s1_pending", 3'd3, 32'h4);
      check("s1_valid_n1", {31'h0, ex_trap_valid_o}, 32'h0);
      irq_src_i = 16'h0; tick();
      check("s1_valid_n2", {31'h0, ex_trap_valid_o}, 32'h1);
      check("s1_id_n2", {27'h0, ex_trap_id_o}, 32'd2);
      ex_trap_ready_i = 1'b1; tick(); ex_trap_ready_i = 1'b0;
      check("s1_valid_busy", {31'h0, ex_trap_valid_o}, 32'h0);
      rd_check("s1_pend_clr", 3'd3, 32'h0);
      rd_check("s1_status", 3'd4, 32'h202);
      ex_trap_cplet_i = 1'b1; tick(); ex_trap_cplet_i = 1'b0;
      rd_check("s1_status_idle", 3'd4, 32'h0);

      // Priority order with ties: src1/5 at PRIO 3, src3 at PRIO 2.
      cfg_write(3'd0, 32'h002A);
      cfg_write(3'd1, 32'h0000_0C8C);
      irq_src_i = 16'h002A; tick();
      irq_src_i = 16'h0; tick();
      check("s2_id_first", {27'h0, ex_trap_id_o}, 32'd1);
      claim_and_complete(); tick();
      check("s2_id_second", {27'h0, ex_trap_id_o}, 32'd5);
      claim_and_complete(); tick();
      check("s2_id_third", {27'h0, ex_trap_id_o}, 32'd3);
      claim_and_complete(); tick();

      // Threshold gating.
      cfg_write(3'd0, 32'h0040);
      cfg_write(3'd1, 32'h0000_2000);
      cfg_write(3'd2, 32'h2);
      irq_src_i = 16'h0040; tick(); irq_src_i = 16'h0; tick(3);
      check("s3_blocked", {31'h0, ex_trap_valid_o}, 32'h0);
      cfg_write(3'd2, 32'h1);
      check("s3_valid_w1", {31'h0, ex_trap_valid_o}, 32'h0);
      tick();
      check("s3_valid_w2", {31'h0, ex_trap_valid_o}, 32'h1);
      check("s3_id", {27'h0, ex_trap_id_o}, 32'd6);
      claim_and_complete(); tick();

      // Edge while BUSY accumulates and is offered after completion.
      cfg_write(3'd0, 32'h0050);
      cfg_write(3'd1, 32'h0000_2200);
      irq_src_i = 16'h0040; tick(); irq_src_i = 16'h0; tick();
      ex_trap_ready_i = 1'b1; tick(); ex_trap_ready_i = 1'b0;
      irq_src_i = 16'h0010; tick(); irq_src_i = 16'h0; tick(2);
      check("s4_busy_valid", {31'h0, ex_trap_valid_o}, 32'h0);
      rd_check("s4_pending", 3'd3, 32'h10);
      ex_trap_cplet_i = 1'b1; tick(); ex_trap_cplet_i = 1'b0;
      tick();
      check("s4_valid", {31'h0, ex_trap_valid_o}, 32'h1);
      check("s4_id", {27'h0, ex_trap_id_o}, 32'd4);
      claim_and_complete(); tick();

      // Withdrawal of an offer, then stray ready/cplet in IDLE.
      cfg_write(3'd0, 32'h0080);
      cfg_write(3'd1, 32'h0000_8000);
      irq_src_i = 16'h0080; tick(); irq_src_i = 16'h0; tick();
      check("s5_id", {27'h0, ex_trap_id_o}, 32'd7);
      cfg_write(3'd0, 32'h0);
      tick();
      check("s5_withdrawn", {31'h0, ex_trap_valid_o}, 32'h0);
      rd_check("s5_pending", 3'd3, 32'h80);
      ex_trap_ready_i = 1'b1; tick(); ex_trap_ready_i = 1'b0;
      ex_trap_cplet_i = 1'b1; tick(); ex_trap_cplet_i = 1'b0;
      rd_check("s5_status", 3'd4, 32'h0);
      rd_check("s5_pending2", 3'd3, 32'h80);

      // Reset while BUSY with pending bits and lines held high.
      cfg_write(3'd0, 32'h0080);
      tick();
      check("s6_id", {27'h0, ex_trap_id_o}, 32'd7);
      ex_trap_ready_i = 1'b1; tick(); ex_trap_ready_i = 1'b0;
      irq_src_i = 16'h0018; tick(2);
      rd_check("s6_pending", 3'd3, 32'h18);
      rst = 1'b1; tick();
      check("s6_rst_valid", {31'h0, ex_trap_valid_o}, 32'h0);
      for (int a = 0; a < 5; a++) rd_check("s6_rst_read", 3'(a), 32'h0);
      rst = 1'b0;
      cfg_write(3'd0, 32'h0018);
      cfg_write(3'd1, 32'h0000_0280);
      tick(3);
      check("s6_held_valid", {31'h0, ex_trap_valid_o}, 32'h0);
      rd_check("s6_held_pend", 3'd3, 32'h0);
      irq_src_i = 16'h0010; tick();
      irq_src_i = 16'h0018; tick(2);
      check("s6_reedge_valid", {31'h0, ex_trap_valid_o}, 32'h1);
      check("s6_reedge_id", {27'h0, ex_trap_id_o}, 32'd3);
      tick(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
